// File: rtl/nfa_report_collector.sv
// nfa_report_collector: symbol metering, report OR-reduction and
// credit-protected report FIFO for an NFA automata cluster.
module nfa_report_collector #(
    parameter int NUM_CHANNELS        = 7,
    parameter int SOURCES_PER_CHANNEL = 4,
    parameter int SYMBOL_W            = 8,
    parameter int OFFSET_W            = 32,
    parameter int FIFO_DEPTH          = 16,
    parameter int STAGE_LATENCY       = 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        run,
    input  logic                                        clear,
    input  logic                                        in_symbol_valid,
    output logic                                        in_symbol_ready,
    input  logic [SYMBOL_W-1:0]                         in_symbols,
    output logic [SYMBOL_W-1:0]                         stage_symbols,
    output logic                                        stage_enable,
    input  logic [NUM_CHANNELS*SOURCES_PER_CHANNEL-1:0] stage_reports,
    output logic [NUM_CHANNELS-1:0]                     ltl_reports,
    output logic                                        rpt_valid,
    input  logic                                        rpt_ready,
    output logic [OFFSET_W-1:0]                         rpt_offset,
    output logic [NUM_CHANNELS-1:0]                     rpt_mask,
    output logic [OFFSET_W-1:0]                         symbol_count,
    output logic                                        busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;
    localparam int LAST = STAGE_LATENCY - 1;

    logic [STAGE_LATENCY-1:0] slot_v;
    logic [OFFSET_W-1:0]      slot_off [STAGE_LATENCY];
    logic [CW-1:0]            fifo_count;
    logic [CW-1:0]            fifo_count_nx;
    logic [CW-1:0]            inflight;
    logic [PW-1:0]            rd_ptr;
    logic [PW-1:0]            wr_ptr;
    logic [OFFSET_W-1:0]      mem_off  [FIFO_DEPTH];
    logic [NUM_CHANNELS-1:0]  mem_mask [FIFO_DEPTH];
    logic [NUM_CHANNELS-1:0]  mask;
    logic                     credit;
    logic                     accept;
    logic                     push;
    logic                     pop;

    // Number of occupied delay-line slots; each may still produce a record.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < STAGE_LATENCY; i++) begin
            inflight = inflight + CW'(slot_v[i]);
        end
    end

    // Credits cover every record that could still be pushed; pops are not credited.
    assign credit = ({1'b0, fifo_count} + {1'b0, inflight}) < SW'(FIFO_DEPTH);
    assign in_symbol_ready = ~reset & run & ~clear & credit;
    assign accept = in_symbol_valid & in_symbol_ready;
    assign stage_symbols = in_symbols;
    assign stage_enable = accept;

    // Per-channel OR of report wires, qualified by the evaluated slot.
    always_comb begin
        mask = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            mask[c] = slot_v[LAST] &
                (|stage_reports[c*SOURCES_PER_CHANNEL +: SOURCES_PER_CHANNEL]);
        end
    end

    assign push = |mask;
    assign pop = rpt_valid & rpt_ready;
    assign fifo_count_nx = fifo_count + CW'(push) - CW'(pop);
    assign busy = (inflight != '0) | (fifo_count != '0);
    assign rpt_offset = mem_off[rd_ptr];
    assign rpt_mask = mem_mask[rd_ptr];

    // Delay line carrying {valid, offset} until the stage reports are valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_v <= '0;
            for (int i = 0; i < STAGE_LATENCY; i++) slot_off[i] <= '0;
        end else if (clear) begin
            slot_v <= '0;
        end else begin
            slot_v[0] <= accept;
            slot_off[0] <= symbol_count;
            for (int i = 1; i < STAGE_LATENCY; i++) begin
                slot_v[i] <= slot_v[i-1];
                slot_off[i] <= slot_off[i-1];
            end
        end
    end

    // Running offset of accepted symbols, wrapping naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) symbol_count <= '0;
        else if (clear) symbol_count <= '0;
        else if (accept) symbol_count <= symbol_count + 1'b1;
    end

    // Registered per-channel report pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ltl_reports <= '0;
        else if (clear) ltl_reports <= '0;
        else ltl_reports <= mask;
    end

    // FIFO pointers, occupancy and head-valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fifo_count <= '0;
            rpt_valid <= 1'b0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fifo_count <= '0;
            rpt_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count_nx;
            rpt_valid <= (fifo_count_nx != '0);
        end
    end

    // FIFO storage; zeroed on reset so the head reads 0 while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_off[i] <= '0;
                mem_mask[i] <= '0;
            end
        end else if (push && !clear) begin
            mem_off[wr_ptr] <= slot_off[LAST];
            mem_mask[wr_ptr] <= mask;
        end
    end
endmodule

// File: tb/tb_nfa_report_collector.sv
// Self-checking bench for nfa_report_collector: queue-based reference
// model compared every cycle, plus directed literal checks.
module tb_nfa_report_collector;
    localparam int NC = 7;
    localparam int D = 16;
    localparam int L = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        clear = 1'b0;
    logic        in_symbol_valid = 1'b0;
    logic        rpt_ready = 1'b0;
    logic [7:0]  in_symbols = '0;
    logic [27:0] stage_reports;

    logic        a_ready, a_enable, a_rvalid, a_busy;
    logic [7:0]  a_ssym;
    logic [6:0]  a_ltl, a_rmask;
    logic [31:0] a_roff, a_count;
    logic        b_ready, b_enable, b_rvalid, b_busy;
    logic [7:0]  b_ssym;
    logic [6:0]  b_ltl, b_rmask;
    logic [3:0]  b_roff, b_count;

    nfa_report_collector dut_a (
        .clk(clk), .reset(reset), .run(run), .clear(clear),
        .in_symbol_valid(in_symbol_valid), .in_symbol_ready(a_ready),
        .in_symbols(in_symbols), .stage_symbols(a_ssym),
        .stage_enable(a_enable), .stage_reports(stage_reports),
        .ltl_reports(a_ltl), .rpt_valid(a_rvalid), .rpt_ready(rpt_ready),
        .rpt_offset(a_roff), .rpt_mask(a_rmask),
        .symbol_count(a_count), .busy(a_busy)
    );

    nfa_report_collector #(.OFFSET_W(4)) dut_b (
        .clk(clk), .reset(reset), .run(run), .clear(clear),
        .in_symbol_valid(in_symbol_valid), .in_symbol_ready(b_ready),
        .in_symbols(in_symbols), .stage_symbols(b_ssym),
        .stage_enable(b_enable), .stage_reports(stage_reports),
        .ltl_reports(b_ltl), .rpt_valid(b_rvalid), .rpt_ready(rpt_ready),
        .rpt_offset(b_roff), .rpt_mask(b_rmask),
        .symbol_count(b_count), .busy(b_busy)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] off;
        logic [6:0]  mask;
    } rec_t;

    rec_t        fq[$];
    logic [31:0] pq_off[$];
    int          pq_due[$];
    logic [31:0] m_count = '0;
    logic [6:0]  m_ltl = '0;
    int          cyc = 0;
    logic        ev_valid = 1'b0;
    logic [31:0] ev_off = '0;
    logic [27:0] rtab [64];
    logic [27:0] noise = '0;
    logic        chk_en = 1'b0;

    assign stage_reports = ev_valid ? rtab[ev_off[5:0]] : noise;

    function automatic logic m_ready();
        return !reset && run && !clear && ((fq.size() + pq_off.size()) < D);
    endfunction

    function automatic logic [6:0] chan_or(input logic [27:0] r);
        logic [6:0] m;
        for (int c = 0; c < NC; c++) m[c] = |r[c*4 +: 4];
        return m;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic acc;
        logic [6:0] m;
        int pre;
        rec_t r;
        if (reset) begin
            fq.delete(); pq_off.delete(); pq_due.delete();
            m_count = '0;
            m_ltl = '0;
            ev_valid <= 1'b0;
        end else begin
            acc = in_symbol_valid && m_ready();
            if (clear) begin
                fq.delete(); pq_off.delete(); pq_due.delete();
                m_count = '0;
                m_ltl = '0;
            end else begin
                pre = fq.size();
                if (pre > 0 && rpt_ready) void'(fq.pop_front());
                m = '0;
                if (pq_due.size() > 0 && pq_due[0] == cyc) begin
                    m = chan_or(stage_reports);
                    r.off = pq_off.pop_front();
                    void'(pq_due.pop_front());
                    r.mask = m;
                    if (m != '0) begin
                        if (pre >= D) begin
                            mismatched++;
                            $display("FAIL fifo_push_full: occupancy %0d", pre);
                        end
                        fq.push_back(r);
                    end
                end
                m_ltl = m;
                if (acc) begin
                    pq_off.push_back(m_count);
                    pq_due.push_back(cyc + L);
                    m_count = m_count + 1;
                end
            end
            cyc++;
            ev_valid <= (pq_due.size() > 0 && pq_due[0] == cyc);
            ev_off <= (pq_off.size() > 0) ? pq_off[0] : '0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic er;
        if (!reset && chk_en) begin
            er = m_ready();
            chk("a_ready", a_ready, er);
            chk("b_ready", b_ready, er);
            chk("a_enable", a_enable, in_symbol_valid & er);
            chk("a_stage_symbols", a_ssym, in_symbols);
            chk("a_ltl", a_ltl, m_ltl);
            chk("b_ltl", b_ltl, m_ltl);
            chk("a_rpt_valid", a_rvalid, fq.size() != 0);
            chk("b_rpt_valid", b_rvalid, fq.size() != 0);
            if (fq.size() != 0) begin
                chk("a_rpt_offset", a_roff, fq[0].off);
                chk("a_rpt_mask", a_rmask, fq[0].mask);
                chk("b_rpt_offset", b_roff, fq[0].off & 32'hF);
                chk("b_rpt_mask", b_rmask, fq[0].mask);
            end
            chk("a_symbol_count", a_count, m_count);
            chk("b_symbol_count", b_count, m_count & 32'hF);
            chk("a_busy", a_busy, (fq.size() + pq_off.size()) != 0);
            chk("b_busy", b_busy, (fq.size() + pq_off.size()) != 0);
        end
    end

    // ---------------- observation logs ----------------
    rec_t a_log[$];
    logic [3:0] b_log[$];
    int acc_n = 0;
    int ltl2_cyc = -1;
    int acc5_cyc = -2;

    always @(negedge clk) begin
        rec_t r;
        if (!reset) begin
            if (a_rvalid && rpt_ready) begin
                r.off = a_roff;
                r.mask = a_rmask;
                a_log.push_back(r);
            end
            if (b_rvalid && rpt_ready) b_log.push_back(b_roff);
            if (a_enable) acc_n++;
            if (a_ltl[2]) ltl2_cyc = cyc;
            if (a_enable && a_count == 32'd5) acc5_cyc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic feed(input int n);
        in_symbol_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_symbols = 8'($urandom);
            step(1);
        end
        in_symbol_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic logs_clear();
        a_log.delete();
        b_log.delete();
    endtask

    task automatic rtab_fill(input logic all_report);
        for (int i = 0; i < 64; i++)
            rtab[i] = all_report ? (28'd1 << (i % 28)) : 28'd0;
    endtask

    initial begin
        int errs;
        rtab_fill(1'b0);
        step(2);
        chk("reset_ready", a_ready, 0);
        chk("reset_rpt_valid", a_rvalid, 0);
        chk("reset_busy", a_busy, 0);
        reset = 1'b0;
        chk_en = 1'b1;
        step(3);
        chk("idle_ready_run0", a_ready, 0);
        chk("idle_busy", a_busy, 0);

        // single report on offset 5, channel 2 source 3
        run = 1'b1;
        rpt_ready = 1'b1;
        noise = 28'hFFFFFFF;
        rtab[5] = 28'd1 << 11;
        logs_clear();
        feed(10);
        step(5);
        chk("single_count", a_log.size(), 1);
        if (a_log.size() > 0) begin
            chk("single_offset", a_log[0].off, 5);
            chk("single_mask", a_log[0].mask, 7'b0000100);
        end
        chk("single_ltl_latency", ltl2_cyc - acc5_cyc, 2);

        // two channels on the same symbol
        pulse_clear();
        rtab_fill(1'b0);
        rtab[3] = 28'h1000001;
        logs_clear();
        feed(6);
        step(4);
        chk("multi_count", a_log.size(), 1);
        if (a_log.size() > 0) begin
            chk("multi_offset", a_log[0].off, 3);
            chk("multi_mask", a_log[0].mask, 7'b1000001);
        end

        // backpressure: every symbol reports, consumer stalled
        pulse_clear();
        rtab_fill(1'b1);
        noise = 28'h0;
        logs_clear();
        rpt_ready = 1'b0;
        step(1);
        acc_n = 0;
        feed(25);
        chk("bp_accepted", acc_n, 16);
        chk("bp_ready_low", a_ready, 0);
        rpt_ready = 1'b1;
        step(25);
        chk("bp_drained", a_log.size(), 16);
        errs = 0;
        foreach (a_log[i]) if (a_log[i].off != 32'(i)) errs++;
        chk("bp_order_errs", errs, 0);

        // clear with 3 queued records and 1 slot in flight
        pulse_clear();
        logs_clear();
        rpt_ready = 1'b0;
        feed(4);
        chk("clr_pre_busy", a_busy, 1);
        clear = 1'b1;
        #3;
        chk("clr_ready_low", a_ready, 0);
        step(1);
        clear = 1'b0;
        chk("clr_rpt_valid", a_rvalid, 0);
        chk("clr_symbol_count", a_count, 0);
        chk("clr_busy", a_busy, 0);
        rpt_ready = 1'b1;
        feed(1);
        step(4);
        chk("clr_after_count", a_log.size(), 1);
        if (a_log.size() > 0) chk("clr_after_offset", a_log[0].off, 0);

        // offset wrap on the 4-bit instance
        pulse_clear();
        rtab_fill(1'b0);
        rtab[16] = 28'h0000100;
        noise = 28'h5A5A5A5;
        logs_clear();
        feed(20);
        step(4);
        chk("wrap_b_records", b_log.size(), 1);
        if (b_log.size() > 0) chk("wrap_b_offset", b_log[0], 0);
        if (a_log.size() > 0) chk("wrap_a_offset", a_log[0].off, 16);
        chk("wrap_b_count", b_count, 4);
        chk("wrap_a_count", a_count, 20);

        // asynchronous reset in the middle of a stream
        rtab_fill(1'b1);
        rpt_ready = 1'b0;
        feed(5);
        in_symbol_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("areset_ready", a_ready, 0);
        chk("areset_enable", a_enable, 0);
        chk("areset_ltl", a_ltl, 0);
        chk("areset_rpt_valid", a_rvalid, 0);
        chk("areset_rpt_offset", a_roff, 0);
        chk("areset_rpt_mask", a_rmask, 0);
        chk("areset_count", a_count, 0);
        chk("areset_busy", a_busy, 0);
        chk("areset_b_valid", b_rvalid, 0);
        chk("areset_b_count", b_count, 0);
        in_symbol_valid = 1'b0;
        step(2);
        reset = 1'b0;
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule

// File: doc/nfa_report_collector.md
# nfa_report_collector

Parametrised report front-end for an NFA automata cluster. It meters the input symbol stream into the automata stage with a valid/ready handshake and tags every accepted symbol with a running offset. It OR-reduces the stage's per-state report wires into per-channel report bits and queues every reporting symbol as an {offset, channel mask} record in an internal FIFO. Credit-based backpressure guarantees no report is lost. It replaces the fixed seven-channel, four-source combinational OR top of earlier clusters.

## Interface
- NUM_CHANNELS, 7, report channels (ltl outputs).
- SOURCES_PER_CHANNEL, 4, stage report wires OR-ed per channel.
- SYMBOL_W, 8, symbol width.
- OFFSET_W, 32, symbol offset / counter width.
- FIFO_DEPTH, 16, report FIFO entries; power of two, must exceed STAGE_LATENCY.
- STAGE_LATENCY, 1, cycles from symbol accept to valid stage_reports; at least 1.

- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- run  in  1  enables symbol acceptance.
- clear  in  1  synchronous soft flush.
- in_symbol_valid  in  1  input symbol valid.
- in_symbol_ready  out  1  block accepts the symbol this cycle.
- in_symbols  in  SYMBOL_W  input symbol.
- stage_symbols  out  SYMBOL_W  symbol to the automata stage, equal to in_symbols.
- stage_enable  out  1  stage advances one symbol; equal to in_symbol_valid & in_symbol_ready.
- stage_reports  in  NUM_CHANNELS*SOURCES_PER_CHANNEL  report wires; channel c owns bits [c*SOURCES_PER_CHANNEL +: SOURCES_PER_CHANNEL].
- ltl_reports  out  NUM_CHANNELS  registered per-channel report pulse.
- rpt_valid  out  1  FIFO head valid.
- rpt_ready  in  1  consumer pops the head.
- rpt_offset  out  OFFSET_W  offset of the reporting symbol.
- rpt_mask  out  NUM_CHANNELS  channels that reported on that symbol.
- symbol_count  out  OFFSET_W  symbols accepted since reset or clear.
- busy  out  1  in-flight slot pending or FIFO non-empty.

## Operation
- Reset: all outputs are 0. The FIFO, the delay line and symbol_count are emptied or zeroed.
- Credit: in_symbol_ready = run & ~clear & (fifo_count + inflight < FIFO_DEPTH). inflight is the number of valid delay-line slots. The pop in the current cycle is not credited.
- Accept at cycle t, when in_symbol_valid & in_symbol_ready:
  - the slot {valid=1, offset=symbol_count} enters a STAGE_LATENCY-deep delay line;
  - symbol_count increments and wraps modulo 2^OFFSET_W.
- Evaluate at cycle t+STAGE_LATENCY:
  - mask[c] = OR of the channel c bits of stage_reports, qualified by the slot valid bit;
  - if mask is non-zero, push {offset, mask} at the end of the cycle;
  - stage_reports is ignored whenever the slot is invalid.
- ltl_reports <= qualified mask every cycle, so it is 0 when no valid slot is evaluated.
- FIFO:
  - pop when rpt_valid & rpt_ready;
  - simultaneous push and pop are both performed and fifo_count is unchanged;
  - a push to a full FIFO is unreachable by construction; the bench asserts it never happens.
- clear (priority over everything except reset), effective at the clock edge:
  - delay line invalidated, FIFO emptied, symbol_count set to 0, ltl_reports set to 0;
  - in_symbol_ready is 0 during the clear cycle.
- run low:
  - stops acceptance only;
  - in-flight slots still evaluate and the FIFO still drains.
- busy = (inflight != 0) | (fifo_count != 0).

## Timing
- in_symbol_ready depends only on registered state, run and clear, never on in_symbol_valid.
- Report latency:
  - symbol accepted in cycle t gives ltl_reports pulse in cycle t+STAGE_LATENCY+1;
  - its record becomes rpt_valid earliest in cycle t+STAGE_LATENCY+1.
- rpt_valid, rpt_offset and rpt_mask are registered. They hold stable while rpt_valid & ~rpt_ready.
- Throughput is one symbol per cycle while rpt_ready=1 and FIFO_DEPTH > STAGE_LATENCY.
- Records leave in offset order.

## Test plan
- Reset and idle:
  - assert reset mid-stream -> all outputs 0 asynchronously;
  - after release with run=0 -> in_symbol_ready stays 0 and busy=0.
- Single report (defaults): stream offsets 0..9 with stage bit 11 (channel 2, source 3) high only in the evaluation cycle of offset 5 -> one record with rpt_offset=5, rpt_mask=7'b0000100; ltl_reports[2] pulses 2 cycles after that accept.
- Multi-channel same symbol: bits 0 and 24 high together for offset 3 -> exactly one record with rpt_mask=7'b1000001.
- Backpressure: rpt_ready=0 and every symbol reports -> exactly 16 symbols accepted, then in_symbol_ready=0. Raising rpt_ready yields offsets 0..15 in order with no loss or duplication.
- Clear mid-operation: FIFO holds 3 records and 1 slot is in flight; pulse clear -> rpt_valid=0 and symbol_count=0 next cycle, the flushed slot's reports never appear, and the next accepted symbol has offset 0.
- Wrap (OFFSET_W=4): 20 symbols with a report on the 17th -> rpt_offset=0 and symbol_count=4 at the end.
